// File: rtl/ex_mem_skid_if.sv
// ex_mem_skid_if
//   Handshake and payload bundle between the EX stage, the EX/MEM skid
//   register and the MEM stage.
//   EX side   : In_Valid, In_Ready, WB_EX, MEM_EX, WN_EX, RD2_EX, DataOut_EX
//   MEM side  : Out_Valid, Out_Ready, WB_MEM, MEM_MEM, WN_MEM, RD2_MEM,
//               DataOut_MEM
//   Status    : Occupancy (entries held, 0..2)
//   master modport = the environment around the register (EX and MEM),
//   slave modport  = the register itself.
interface ex_mem_skid_if #(
    parameter int WB_W   = 2,
    parameter int MEM_W  = 2,
    parameter int WN_W   = 5,
    parameter int DATA_W = 32
);
    logic              In_Valid;
    logic              In_Ready;
    logic [WB_W-1:0]   WB_EX;
    logic [MEM_W-1:0]  MEM_EX;
    logic [WN_W-1:0]   WN_EX;
    logic [DATA_W-1:0] RD2_EX;
    logic [DATA_W-1:0] DataOut_EX;

    logic              Out_Valid;
    logic              Out_Ready;
    logic [WB_W-1:0]   WB_MEM;
    logic [MEM_W-1:0]  MEM_MEM;
    logic [WN_W-1:0]   WN_MEM;
    logic [DATA_W-1:0] RD2_MEM;
    logic [DATA_W-1:0] DataOut_MEM;

    logic [1:0]        Occupancy;

    modport master (
        output In_Valid, WB_EX, MEM_EX, WN_EX, RD2_EX, DataOut_EX, Out_Ready,
        input  In_Ready, Out_Valid, WB_MEM, MEM_MEM, WN_MEM, RD2_MEM,
               DataOut_MEM, Occupancy
    );

    modport slave (
        input  In_Valid, WB_EX, MEM_EX, WN_EX, RD2_EX, DataOut_EX, Out_Ready,
        output In_Ready, Out_Valid, WB_MEM, MEM_MEM, WN_MEM, RD2_MEM,
               DataOut_MEM, Occupancy
    );
endinterface

// File: rtl/ex_mem_skid_reg.sv
// ex_mem_skid_reg
//   EX->MEM pipeline register with valid/ready flow control, a 2-entry skid
//   buffer and a synchronous flush that injects a bubble.
//   Ports:
//     Clk   - clock, rising edge
//     Rst   - synchronous reset, active-high (priority over Flush)
//     Flush - synchronous flush, active-high; drops both entries and any
//             same-cycle push
//     bus   - ex_mem_skid_if slave: EX-side valid/ready + payload in,
//             MEM-side valid/ready + payload out, Occupancy
//
//   state | meaning
//   ------+-----------------------------------------------
//   EMPTY | nothing held, Out_Valid=0
//   ONE   | main register holds the head entry
//   FULL  | main holds the head, skid holds the next entry
module ex_mem_skid_reg #(
    parameter int WB_W   = 2,
    parameter int MEM_W  = 2,
    parameter int WN_W   = 5,
    parameter int DATA_W = 32
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          Flush,
    ex_mem_skid_if.slave  bus
);
    localparam int PW      = WB_W + MEM_W + WN_W + 2 * DATA_W;
    localparam int OFF_RD2 = DATA_W;
    localparam int OFF_WN  = 2 * DATA_W;
    localparam int OFF_MEM = OFF_WN + WN_W;
    localparam int OFF_WB  = OFF_MEM + MEM_W;

    // Encoding doubles as the Occupancy count.
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]    state;
    logic [PW-1:0] main_q;
    logic [PW-1:0] skid_q;
    logic [PW-1:0] in_pl;
    logic          push;
    logic          pop;
    logic          out_valid;

    assign in_pl = {bus.WB_EX, bus.MEM_EX, bus.WN_EX, bus.RD2_EX, bus.DataOut_EX};

    // In_Ready comes from the state register only, so MEM's Out_Ready
    // never reaches EX combinationally; the skid entry absorbs the cycle
    // of slack this costs.
    assign bus.In_Ready = (state != FULL);
    assign out_valid    = (state != EMPTY);
    assign bus.Out_Valid = out_valid;
    assign bus.Occupancy = state;

    assign push = bus.In_Valid & (state != FULL);
    assign pop  = out_valid & bus.Out_Ready;

    always_ff @(posedge Clk) begin
        if (Rst || Flush) begin
            // A pop in a flush cycle needs no action: MEM already took it.
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        main_q <= in_pl;
                        state  <= ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        main_q <= in_pl;
                    end else if (push) begin
                        skid_q <= in_pl;
                        state  <= FULL;
                    end else if (pop) begin
                        state  <= EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        main_q <= skid_q;
                        state  <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    // Control fields are gated so a bubble can never write back or touch
    // memory; the data fields keep their last value.
    assign bus.WB_MEM      = out_valid ? main_q[OFF_WB +: WB_W]   : '0;
    assign bus.MEM_MEM     = out_valid ? main_q[OFF_MEM +: MEM_W] : '0;
    assign bus.WN_MEM      = main_q[OFF_WN +: WN_W];
    assign bus.RD2_MEM     = main_q[OFF_RD2 +: DATA_W];
    assign bus.DataOut_MEM = main_q[0 +: DATA_W];
endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// tb_ex_mem_skid_reg
//   Directed bench for ex_mem_skid_reg (WB_W=3, DATA_W=64) with a queue
//   scoreboard: accepted entries are queued at each edge, and every pop is
//   compared in order against the queue head.
module tb_ex_mem_skid_reg;
    localparam int WB_W   = 3;
    localparam int MEM_W  = 2;
    localparam int WN_W   = 5;
    localparam int DATA_W = 64;

    typedef struct packed {
        logic [WB_W-1:0]   wb;
        logic [MEM_W-1:0]  mem;
        logic [WN_W-1:0]   wn;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] dout;
    } entry_t;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    logic Flush = 1'b0;

    int checks = 0;
    int errors = 0;
    entry_t sb[$];

    ex_mem_skid_if #(.WB_W(WB_W), .MEM_W(MEM_W), .WN_W(WN_W), .DATA_W(DATA_W)) bus ();

    ex_mem_skid_reg #(.WB_W(WB_W), .MEM_W(MEM_W), .WN_W(WN_W), .DATA_W(DATA_W)) dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .Flush (Flush),
        .bus   (bus.slave)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic put(input logic v, input logic [WB_W-1:0] wb, input logic [MEM_W-1:0] mem,
                       input logic [WN_W-1:0] wn, input logic [DATA_W-1:0] rd2,
                       input logic [DATA_W-1:0] dout);
        bus.In_Valid   = v;
        bus.WB_EX      = wb;
        bus.MEM_EX     = mem;
        bus.WN_EX      = wn;
        bus.RD2_EX     = rd2;
        bus.DataOut_EX = dout;
    endtask

    // Monitor: inputs are stable mid-cycle, so the transfers of the coming
    // edge are decided here from the model's own occupancy.
    always @(negedge Clk) begin
        int n;
        entry_t got;
        if (Rst) begin
            sb.delete();
        end else begin
            n = sb.size();
            chk("occupancy", 128'(bus.Occupancy), 128'(n));
            chk("in_ready", 128'(bus.In_Ready), 128'(n < 2));
            chk("out_valid", 128'(bus.Out_Valid), 128'(n != 0));
            if (n == 0) begin
                chk("bubble_wb", 128'(bus.WB_MEM), 128'(0));
                chk("bubble_mem", 128'(bus.MEM_MEM), 128'(0));
            end
            if (bus.Out_Ready && n > 0) begin
                got = '{bus.WB_MEM, bus.MEM_MEM, bus.WN_MEM, bus.RD2_MEM, bus.DataOut_MEM};
                chk("pop_entry_lo", 128'(got[127:0]), 128'(sb[0][127:0]));
                chk("pop_ctrl", 128'(got[$bits(entry_t)-1:128]), 128'(sb[0][$bits(entry_t)-1:128]));
                void'(sb.pop_front());
            end
            if (Flush) begin
                sb.delete();
            end else if (bus.In_Valid && n < 2) begin
                sb.push_back('{bus.WB_EX, bus.MEM_EX, bus.WN_EX, bus.RD2_EX, bus.DataOut_EX});
            end
        end
    end

    initial begin
        bus.Out_Ready = 1'b0;
        put(1'b1, 3'b111, 2'b11, 5'd31, 64'hDEAD, 64'hBEEF);

        // Reset with In_Valid high: inputs ignored.
        step();
        step();
        chk("rst_out_valid", 128'(bus.Out_Valid), 128'(0));
        chk("rst_wb", 128'(bus.WB_MEM), 128'(0));
        chk("rst_occ", 128'(bus.Occupancy), 128'(0));
        chk("rst_in_ready", 128'(bus.In_Ready), 128'(1));
        chk("rst_dout", 128'(bus.DataOut_MEM), 128'(0));
        Rst = 1'b0;
        put(1'b0, '0, '0, '0, '0, '0);
        step();

        // Streaming: one-cycle latency, occupancy stays 1.
        bus.Out_Ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            put(1'b1, 3'b001, 2'b10, 5'(i), 64'(i * 16), 64'(i));
            step();
            chk("stream_dout", 128'(bus.DataOut_MEM), 128'(i));
            chk("stream_occ", 128'(bus.Occupancy), 128'(1));
        end
        put(1'b0, '0, '0, '0, '0, '0);
        step();
        chk("stream_drained", 128'(bus.Occupancy), 128'(0));

        // Stall: A and B fill both entries; C is offered while full.
        bus.Out_Ready = 1'b0;
        put(1'b1, 3'b010, 2'b01, 5'd10, 64'h1A, 64'hA);
        step();
        put(1'b1, 3'b011, 2'b01, 5'd11, 64'h1B, 64'hB);
        step();
        chk("stall_occ", 128'(bus.Occupancy), 128'(2));
        chk("stall_in_ready", 128'(bus.In_Ready), 128'(0));
        chk("stall_head", 128'(bus.DataOut_MEM), 128'(64'hA));
        put(1'b1, 3'b100, 2'b11, 5'd12, 64'h1C, 64'hC);
        step();
        chk("stall_still_full", 128'(bus.Occupancy), 128'(2));
        bus.Out_Ready = 1'b1;
        step();
        put(1'b0, '0, '0, '0, '0, '0);
        chk("unstall_b", 128'(bus.DataOut_MEM), 128'(64'hB));
        chk("unstall_occ", 128'(bus.Occupancy), 128'(1));
        step();
        chk("unstall_empty", 128'(bus.Occupancy), 128'(0));

        // Flush while FULL with a push offered.
        bus.Out_Ready = 1'b0;
        put(1'b1, 3'b101, 2'b10, 5'd20, 64'h2A, 64'h2A);
        step();
        put(1'b1, 3'b110, 2'b10, 5'd21, 64'h2B, 64'h2B);
        step();
        put(1'b1, 3'b111, 2'b11, 5'd22, 64'hDD, 64'hDD);
        Flush = 1'b1;
        step();
        Flush = 1'b0;
        put(1'b0, '0, '0, '0, '0, '0);
        chk("flush_out_valid", 128'(bus.Out_Valid), 128'(0));
        chk("flush_wb", 128'(bus.WB_MEM), 128'(0));
        chk("flush_mem", 128'(bus.MEM_MEM), 128'(0));
        chk("flush_occ", 128'(bus.Occupancy), 128'(0));
        chk("flush_zeroed", 128'(bus.DataOut_MEM), 128'(0));
        bus.Out_Ready = 1'b1;
        step();
        step();

        // Flush in ONE with a same-cycle pop: the popped entry still counts.
        put(1'b1, 3'b001, 2'b01, 5'd3, 64'h33, 64'h33);
        step();
        put(1'b1, 3'b010, 2'b10, 5'd4, 64'h44, 64'h44);
        Flush = 1'b1;
        step();
        Flush = 1'b0;
        put(1'b0, '0, '0, '0, '0, '0);
        chk("flush_pop_occ", 128'(bus.Occupancy), 128'(0));

        // Bubble gating: control zeroed, destination register held.
        bus.Out_Ready = 1'b0;
        put(1'b1, 3'b011, 2'b01, 5'd17, 64'h55, 64'h77);
        step();
        put(1'b0, '0, '0, '0, '0, '0);
        chk("gate_wb_valid", 128'(bus.WB_MEM), 128'(3'b011));
        chk("gate_mem_valid", 128'(bus.MEM_MEM), 128'(2'b01));
        bus.Out_Ready = 1'b1;
        step();
        step();
        chk("gate_wb_bubble", 128'(bus.WB_MEM), 128'(0));
        chk("gate_mem_bubble", 128'(bus.MEM_MEM), 128'(0));
        chk("gate_wn_held", 128'(bus.WN_MEM), 128'(5'd17));
        chk("gate_dout_held", 128'(bus.DataOut_MEM), 128'(64'h77));

        // Reset mid-stall.
        bus.Out_Ready = 1'b0;
        put(1'b1, 3'b001, 2'b01, 5'd1, 64'h1, 64'h1);
        step();
        step();
        chk("midstall_full", 128'(bus.Occupancy), 128'(2));
        Rst = 1'b1;
        step();
        Rst = 1'b0;
        put(1'b0, '0, '0, '0, '0, '0);
        chk("midstall_rst_occ", 128'(bus.Occupancy), 128'(0));
        chk("midstall_rst_ready", 128'(bus.In_Ready), 128'(1));

        // Randomised traffic with occasional flushes.
        for (int c = 0; c < 3000; c++) begin
            put(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                5'($urandom_range(0, 31)), {$urandom, $urandom}, {$urandom, $urandom});
            bus.Out_Ready = 1'($urandom_range(0, 1));
            Flush = ($urandom_range(0, 63) == 0);
            step();
        end
        Flush = 1'b0;
        put(1'b0, '0, '0, '0, '0, '0);
        bus.Out_Ready = 1'b1;
        step();
        step();
        step();
        chk("final_queue_empty", 128'(sb.size()), 128'(0));
        chk("final_occ", 128'(bus.Occupancy), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
